// File: rtl/jtdd2_snd_cmd_pkg.sv
// Shared types and constants for the main-to-sound command channel.
// The FSM encoding and the GAP counter width live here.
package jtdd2_snd_cmd_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StAssert = 2'd2,
        StGap    = 2'd3
    } snd_state_e;

    localparam int unsigned GAP_DEFAULT = 16;

    // GAP counter width: clog2(GAP), never narrower than one bit
    function automatic int unsigned gap_cnt_width(input int unsigned gap);
        return (gap < 2) ? 1 : unsigned'($clog2(gap));
    endfunction

    localparam int unsigned GAP_CW_DEFAULT = gap_cnt_width(GAP_DEFAULT);

endpackage

// File: rtl/jtdd2_cmd_fifo.sv
// Command byte FIFO: storage, pointers, occupancy and the sticky overflow flag.
// head always shows the entry at the read pointer.
module jtdd2_cmd_fifo #(
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    input  logic          ovf_clr,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          push_ok, pop_ok;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign ovf   = ovf_q;
    assign head  = mem[rd_ptr_q];

    assign pop_ok  = pop & ~empty;
    // A same-cycle pop frees the slot, so a write into a full FIFO is accepted
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
        else if (!push_ok && pop_ok) level_d = level_q - 1'b1;
        if (ovf_clr)                 ovf_d = 1'b0;
        else if (push && !push_ok)   ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: rtl/jtdd2_snd_cmd.sv
// Main-CPU to sound-CPU command channel: FIFO-buffered commands presented one at a
// time on snd_latch, each announced by a fresh rising edge on snd_irq.
module jtdd2_snd_cmd
    import jtdd2_snd_cmd_pkg::*;
#(
    parameter int unsigned AW  = 2,
    parameter int unsigned GAP = GAP_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          main_wr,
    input  logic [7:0]    main_din,
    input  logic          ovf_clr,
    input  logic          snd_rd,
    output logic [7:0]    snd_latch,
    output logic          snd_irq,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf
);
    localparam int unsigned CW = gap_cnt_width(GAP);

    snd_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    latch_q, latch_d;
    logic          irq_q, irq_d;
    logic          rd_l_q;
    logic          rd_fall;
    logic          pop;
    logic [7:0]    head;

    jtdd2_cmd_fifo #(
        .AW (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (main_wr),
        .pop     (pop),
        .din     (main_din),
        .ovf_clr (ovf_clr),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .ovf     (ovf)
    );

    assign rd_fall   = rd_l_q & ~snd_rd;
    assign snd_latch = latch_q;
    assign snd_irq   = irq_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;
        irq_d   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) state_d = StLoad;
            end
            StLoad: begin
                latch_d = head;
                state_d = StAssert;
            end
            StAssert: begin
                if (rd_fall) begin
                    pop = 1'b1;
                    // A write in the pop cycle is always accepted, so it keeps the FIFO busy
                    if (level != (AW+1)'(1) || main_wr) begin
                        state_d = StGap;
                        cnt_d   = CW'(GAP - 1);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    irq_d = 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == '0) state_d = StLoad;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            latch_q <= 8'h00;
            irq_q   <= 1'b0;
            rd_l_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            irq_q   <= irq_d;
            rd_l_q  <= snd_rd;
        end
    end

endmodule

// File: tb/tb_jtdd2_snd_cmd.sv
// Bench for jtdd2_snd_cmd: table vectors, hand sequences for the timing corners and
// a randomized run checked every cycle against a queue-based reference model.
module tb_jtdd2_snd_cmd;
    localparam int unsigned AW    = 2;
    localparam int unsigned GAP   = 16;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          main_wr;
    logic [7:0]    main_din;
    logic          ovf_clr;
    logic          snd_rd;
    logic [7:0]    snd_latch;
    logic          snd_irq;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          ovf;

    jtdd2_snd_cmd #(
        .AW  (AW),
        .GAP (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .main_wr   (main_wr),
        .main_din  (main_din),
        .ovf_clr   (ovf_clr),
        .snd_rd    (snd_rd),
        .snd_latch (snd_latch),
        .snd_irq   (snd_irq),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of pending bytes plus an edge countdown to the next load
    logic [7:0] mq[$];
    logic [7:0] m_latch;
    bit         m_irq, m_ovf, m_rd_l, m_active;
    int         m_delay;

    logic [7:0] seen[$];
    bit         irq_prev;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic       clr;
        logic [7:0] latch;
        logic       irq;
        int         lvl;
        logic       full;
        logic       ovf;
    } vec_t;
    vec_t tab[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_latch  = 8'h00;
        m_irq    = 1'b0;
        m_ovf    = 1'b0;
        m_rd_l   = 1'b0;
        m_active = 1'b0;
        m_delay  = 0;
    endtask

    task automatic model_edge();
        bit         fall, pop_e, push_e, was_nonempty, active_pre;
        int         delay_pre;
        logic [7:0] front;
        if (rst) begin
            model_reset();
            return;
        end
        fall         = m_rd_l && !snd_rd;
        pop_e        = m_active && fall;
        push_e       = main_wr && (mq.size() < DEPTH || pop_e);
        was_nonempty = (mq.size() != 0);
        front        = was_nonempty ? mq[0] : 8'h00;
        active_pre   = m_active;
        delay_pre    = m_delay;
        if (ovf_clr) m_ovf = 1'b0;
        else if (main_wr && !push_e) m_ovf = 1'b1;
        if (pop_e) void'(mq.pop_front());
        if (push_e) mq.push_back(main_din);
        m_irq = active_pre && !pop_e;
        if (active_pre) begin
            if (pop_e) begin
                m_active = 1'b0;
                // GAP idle edges, then one edge to load the latch
                m_delay  = (mq.size() != 0) ? GAP + 1 : 0;
            end
        end else if (delay_pre > 0) begin
            m_delay--;
            if (m_delay == 0) begin
                m_latch  = front;
                m_active = 1'b1;
            end
        end else if (was_nonempty) begin
            m_delay = 1;
        end
        m_rd_l = snd_rd;
    endtask

    task automatic cmp_model();
        chk("model_latch", 32'(snd_latch), 32'(m_latch));
        chk("model_irq",   32'(snd_irq),   32'(m_irq));
        chk("model_level", 32'(level),     32'(mq.size()));
        chk("model_full",  32'(full),      32'(mq.size() == DEPTH));
        chk("model_empty", 32'(empty),     32'(mq.size() == 0));
        chk("model_ovf",   32'(ovf),       32'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cmp_model();
        if (snd_irq && !irq_prev) seen.push_back(snd_latch);
        irq_prev = snd_irq;
    endtask

    task automatic add(input logic wr, input logic [7:0] din, input logic rd, input logic clr,
                       input logic [7:0] latch, input logic irq, input int lvl,
                       input logic fl, input logic ov);
        vec_t v;
        v.wr = wr; v.din = din; v.rd = rd; v.clr = clr;
        v.latch = latch; v.irq = irq; v.lvl = lvl; v.full = fl; v.ovf = ov;
        tab.push_back(v);
    endtask

    task automatic wait_irq(input int max_cycles);
        int n = 0;
        while (!snd_irq && n < max_cycles) begin
            step();
            n++;
        end
        chk("wait_irq_timeout", 32'(snd_irq), 32'd1);
    endtask

    // Sound CPU read: select held for len cycles, then released (the pop edge)
    task automatic sound_read(input int len);
        snd_rd = 1'b1;
        repeat (len) step();
        snd_rd = 1'b0;
        step();
    endtask

    task automatic write_byte(input logic [7:0] b);
        main_wr  = 1'b1;
        main_din = b;
        step();
        main_wr  = 1'b0;
    endtask

    initial begin
        int k, lat_k, rd_cnt, wr_mod;
        logic [7:0] exp_order[$];

        rst = 1'b1; main_wr = 1'b0; main_din = 8'h00; ovf_clr = 1'b0; snd_rd = 1'b0;
        irq_prev = 1'b0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        chk("reset_latch", 32'(snd_latch), 32'h00);
        chk("reset_irq",   32'(snd_irq),   32'd0);
        chk("reset_level", 32'(level),     32'd0);
        chk("reset_empty", 32'(empty),     32'd1);
        chk("reset_full",  32'(full),      32'd0);
        chk("reset_ovf",   32'(ovf),       32'd0);

        // Single command with E0..E3 latency, then a 6-cycle read
        add(1, 8'h3C, 0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 8'h3C, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 8'h3C, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 8'h00, 1, 0, 8'h3C, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 8'h3C, 0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 8'h3C, 0, 0, 0, 0);
        // Fill, overflow with 8'hEE, clear overflow
        add(1, 8'hAA, 0, 0, 8'h3C, 0, 1, 0, 0);
        add(1, 8'hBB, 0, 0, 8'h3C, 0, 2, 0, 0);
        add(1, 8'hCC, 0, 0, 8'hAA, 0, 3, 0, 0);
        add(1, 8'hDD, 0, 0, 8'hAA, 1, 4, 1, 0);
        add(1, 8'hEE, 0, 0, 8'hAA, 1, 4, 1, 1);
        add(0, 8'h00, 0, 1, 8'hAA, 1, 4, 1, 0);
        // Full FIFO: write coincides with the pop edge
        add(0, 8'h00, 1, 0, 8'hAA, 1, 4, 1, 0);
        add(1, 8'h5A, 0, 0, 8'hAA, 0, 4, 1, 0);

        for (int i = 0; i < tab.size(); i++) begin
            main_wr  = tab[i].wr;
            main_din = tab[i].din;
            snd_rd   = tab[i].rd;
            ovf_clr  = tab[i].clr;
            step();
            chk($sformatf("tab%0d_latch", i), 32'(snd_latch), 32'(tab[i].latch));
            chk($sformatf("tab%0d_irq", i),   32'(snd_irq),   32'(tab[i].irq));
            chk($sformatf("tab%0d_level", i), 32'(level),     32'(tab[i].lvl));
            chk($sformatf("tab%0d_full", i),  32'(full),      32'(tab[i].full));
            chk($sformatf("tab%0d_ovf", i),   32'(ovf),       32'(tab[i].ovf));
        end
        main_wr = 1'b0; ovf_clr = 1'b0; snd_rd = 1'b0;

        // Drain: all accepted bytes in order, 8'hEE never presented
        for (int i = 0; i < 4; i++) begin
            wait_irq(60);
            sound_read(3);
        end
        repeat (3) step();
        chk("drain_level", 32'(level), 32'd0);
        exp_order = '{8'h3C, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h5A};
        chk("drain_count", 32'(seen.size()), 32'(exp_order.size()));
        for (int i = 0; i < exp_order.size() && i < seen.size(); i++)
            chk($sformatf("drain_order%0d", i), 32'(seen[i]), 32'(exp_order[i]));

        // Falling edge while IDLE is ignored
        sound_read(2);
        chk("idle_fall_level", 32'(level), 32'd0);

        // Three back-to-back commands with GAP spacing
        seen.delete();
        write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
        wait_irq(20);
        chk("b2b_first", 32'(snd_latch), 32'h01);
        for (int c = 0; c < 2; c++) begin
            sound_read(3);
            chk($sformatf("b2b_pop_irq%0d", c), 32'(snd_irq), 32'd0);
            k = 0; lat_k = -1;
            while (!snd_irq && k < 60) begin
                step();
                k++;
                if (lat_k < 0 && snd_latch == 8'(c + 2)) lat_k = k;
            end
            chk($sformatf("b2b_irq_low%0d", c), 32'(k), 32'(GAP + 2));
            chk($sformatf("b2b_latch_at%0d", c), 32'(lat_k), 32'(GAP + 1));
            chk($sformatf("b2b_latch%0d", c), 32'(snd_latch), 32'(c + 2));
        end
        sound_read(2);
        repeat (2) step();
        chk("b2b_edges", 32'(seen.size()), 32'd3);
        chk("b2b_level", 32'(level), 32'd0);

        // Falling edge during GAP is ignored, then reset mid-GAP
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        wait_irq(20);
        sound_read(2);
        chk("gap_level", 32'(level), 32'd2);
        step();
        sound_read(1);
        chk("gap_fall_level", 32'(level), 32'd2);
        chk("gap_fall_latch", 32'(snd_latch), 32'h11);
        chk("gap_fall_irq",   32'(snd_irq),   32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_gap_irq",   32'(snd_irq),   32'd0);
        chk("rst_gap_level", 32'(level),     32'd0);
        chk("rst_gap_latch", 32'(snd_latch), 32'h00);
        write_byte(8'h77);
        chk("post_rst_e0_level", 32'(level), 32'd1);
        step();
        step();
        chk("post_rst_e2_latch", 32'(snd_latch), 32'h77);
        chk("post_rst_e2_irq",   32'(snd_irq),   32'd0);
        step();
        chk("post_rst_e3_irq",   32'(snd_irq),   32'd1);
        sound_read(2);

        // Randomized traffic against the model
        rd_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            wr_mod   = (i < 2000) ? 4 : 30;
            main_wr  = ($urandom % wr_mod) == 0;
            main_din = 8'($urandom);
            ovf_clr  = ($urandom % 40) == 0;
            rst      = ($urandom % 700) == 0;
            if (rd_cnt > 0) begin
                snd_rd = 1'b1;
                rd_cnt--;
            end else begin
                snd_rd = 1'b0;
                if (($urandom % 6) == 0) rd_cnt = $urandom_range(1, 8);
            end
            step();
        end
        rst = 1'b0; main_wr = 1'b0; ovf_clr = 1'b0; snd_rd = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
